sha256_msg_schedule: RTL

Message-schedule generator for the SHA-256 compression datapath. It accepts one 512-bit padded message block and produces the 64 schedule words W[0]..W[63], one per handshake. These words feed the word input of the temporary-word (T1/T2) round logic. It is the producer end of the `word` interface that the round logic consumes, and it supports consumer back-pressure so the round engine can stall.

---
 rtl/sha256_pkg.sv | 40 ++++
 rtl/sha256_small_sigma.sv | 15 +
 rtl/sha256_msg_schedule.sv | 85 ++++++++
 3 files changed

// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, round-constant table, schedule state enum and
// the rotate/shift helpers used by the small-sigma functions.
package sha256_pkg;

  localparam int unsigned WORD_W    = 32;
  localparam int unsigned ROUNDS    = 64;
  localparam int unsigned WIN_DEPTH = 16;

  localparam logic [WORD_W-1:0] K_TABLE [ROUNDS] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x,
                                             input int unsigned n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  function automatic logic [WORD_W-1:0] shr(input logic [WORD_W-1:0] x,
                                            input int unsigned n);
    return x >> n;
  endfunction

endpackage

// File: rtl/sha256_small_sigma.sv
// Combinational SHA-256 small sigma: sel=0 gives sigma0, sel=1 gives sigma1.
module sha256_small_sigma
  import sha256_pkg::*;
(
  input  logic              sel,
  input  logic [WORD_W-1:0] x,
  output logic [WORD_W-1:0] y
);

  always_comb begin
    if (sel) y = rotr(x, 17) ^ rotr(x, 19) ^ shr(x, 10);
    else     y = rotr(x, 7)  ^ rotr(x, 18) ^ shr(x, 3);
  end

endmodule

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: emits W[0..63] over a valid/ready handshake from a
// 16-word sliding window. Define SHA256_SCHED_KCONST_EN to add the kconst port.
module sha256_msg_schedule
  import sha256_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [511:0]      block,
  output logic              busy,
  output logic [WORD_W-1:0] word,
  output logic              word_valid,
  input  logic              word_ready,
  output logic [5:0]        word_idx,
  output logic              done
`ifdef SHA256_SCHED_KCONST_EN
  ,
  output logic [WORD_W-1:0] kconst
`endif
);

  state_t            state_q, state_d;
  logic [WORD_W-1:0] win_q [WIN_DEPTH];
  logic [5:0]        t_q;
  logic [WORD_W-1:0] s0, s1, w_new;
  logic              load, xfer;

  sha256_small_sigma u_sigma0 (.sel(1'b0), .x(win_q[1]),  .y(s0));
  sha256_small_sigma u_sigma1 (.sel(1'b1), .x(win_q[14]), .y(s1));

  assign w_new = s1 + win_q[9] + s0 + win_q[0];

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    xfer    = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          load    = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (word_ready) begin
          xfer = 1'b1;
          if (t_q == 6'(ROUNDS - 1)) state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Window holds W[t..t+15]; slot 0 is always the word on offer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      t_q     <= '0;
      for (int i = 0; i < WIN_DEPTH; i++) win_q[i] <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        t_q <= '0;
        for (int i = 0; i < WIN_DEPTH; i++) win_q[i] <= block[511-32*i -: 32];
      end else if (xfer) begin
        t_q <= t_q + 6'd1;
        for (int i = 0; i < WIN_DEPTH-1; i++) win_q[i] <= win_q[i+1];
        win_q[WIN_DEPTH-1] <= w_new;
      end
    end
  end

  assign busy       = (state_q == RUN);
  assign word_valid = (state_q == RUN);
  assign done       = (state_q == DONE);
  assign word       = win_q[0];
  assign word_idx   = t_q;

`ifdef SHA256_SCHED_KCONST_EN
  assign kconst = (state_q == RUN) ? K_TABLE[t_q] : '0;
`endif

endmodule
